// File: rtl/maxpool_window_gen.sv
// rtl/maxpool_window_gen.sv - raster pixel stream to stride-aligned 3x3 window taps
module maxpool_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8,
  parameter int STRIDE     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [DATA_WIDTH-1:0] data_out3,
  output logic [DATA_WIDTH-1:0] data_out4,
  output logic [DATA_WIDTH-1:0] data_out5,
  output logic [DATA_WIDTH-1:0] data_out6,
  output logic [DATA_WIDTH-1:0] data_out7,
  output logic [DATA_WIDTH-1:0] data_out8,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] win_q [9];
  logic [DATA_WIDTH-1:0] win_d [9];
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  // Line buffers carry no reset: rows 0 and 1 rewrite them before any emit.
  logic [DATA_WIDTH-1:0] lb0_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;

  logic end_of_line, end_of_frame, emit;

  always_comb begin
    lb0_rd       = lb0_q[col_q];
    lb1_rd       = lb1_q[col_q];
    end_of_line  = (32'(col_q) == 32'(IMG_WIDTH - 1));
    end_of_frame = end_of_line && (32'(row_q) == 32'(IMG_HEIGHT - 1));
    emit         = (32'(row_q) >= 32'd2) && (32'(col_q) >= 32'd2) &&
                   (((32'(row_q) - 32'd2) % 32'(STRIDE)) == 32'd0) &&
                   (((32'(col_q) - 32'd2) % 32'(STRIDE)) == 32'd0);
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (valid_in) begin
      col_d = end_of_line ? '0 : col_q + 1'b1;
      if (end_of_frame) begin
        row_d = '0;
      end else if (end_of_line) begin
        row_d = row_q + 1'b1;
      end
      // Shift columns left; new right column is {row r-2, row r-1, row r}.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = data_in;
      valid_d  = emit;
      done_d   = end_of_frame;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (valid_in) begin
      lb1_q[col_q] <= lb0_rd;
      lb0_q[col_q] <= data_in;
    end
  end

  assign data_out0  = win_q[0];
  assign data_out1  = win_q[1];
  assign data_out2  = win_q[2];
  assign data_out3  = win_q[3];
  assign data_out4  = win_q[4];
  assign data_out5  = win_q[5];
  assign data_out6  = win_q[6];
  assign data_out7  = win_q[7];
  assign data_out8  = win_q[8];
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_maxpool_window_gen.sv
// tb/tb_maxpool_window_gen.sv - directed-vector bench for maxpool_window_gen
module tb_maxpool_window_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic [31:0] b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic        va, fda, vb, fdb;
  logic [287:0] pa, pb;

  int total = 0;
  int bad   = 0;
  int emits[$];
  logic [287:0] wins[$];
  int fds[$];
  int stray = 0;

  int exp_a[9] = '{18, 20, 22, 34, 36, 38, 50, 52, 54};
  int exp_b[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};

  always #5 clk = ~clk;

  maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(8), .IMG_HEIGHT(8), .STRIDE(2)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .valid_in(valid_a),
    .data_out0(a0), .data_out1(a1), .data_out2(a2), .data_out3(a3), .data_out4(a4),
    .data_out5(a5), .data_out6(a6), .data_out7(a7), .data_out8(a8),
    .valid_out(va), .frame_done(fda)
  );

  maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .valid_in(valid_b),
    .data_out0(b0), .data_out1(b1), .data_out2(b2), .data_out3(b3), .data_out4(b4),
    .data_out5(b5), .data_out6(b6), .data_out7(b7), .data_out8(b8),
    .valid_out(vb), .frame_done(fdb)
  );

  assign pa = {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  assign pb = {b8, b7, b6, b5, b4, b3, b2, b1, b0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic sample(input int which, input int k, input bit accepted);
    logic vo, fd;
    vo = (which == 0) ? va : vb;
    fd = (which == 0) ? fda : fdb;
    if (accepted) begin
      if (vo) begin
        emits.push_back(k);
        wins.push_back((which == 0) ? pa : pb);
      end
      if (fd) fds.push_back(k);
    end else if (vo || fd) begin
      stray++;
    end
  endtask

  task automatic beat(input int which, input logic [31:0] d, input int k);
    if (which == 0) begin
      data_a = d; valid_a = 1'b1;
    end else begin
      data_b = d; valid_b = 1'b1;
    end
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    sample(which, k, 1'b1);
  endtask

  task automatic idle(input int which);
    @(posedge clk); #1;
    sample(which, -1, 1'b0);
  endtask

  task automatic clear_log();
    emits.delete();
    wins.delete();
    fds.delete();
    stray = 0;
  endtask

  // Window emitted at pixel p (raster index) of a W-wide frame holding value k at pixel k.
  task automatic check_win(input string tag, input logic [287:0] w, input int p, input int width);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("%s_t%0d", tag, i * 3 + j), w[(i * 3 + j) * 32 +: 32],
            32'(p - 2 * width - 2 + i * width + j));
      end
    end
  endtask

  task automatic check_frame_a(input string tag, input int base);
    chk({tag, "_n_emit"}, 32'(emits.size()), 32'd9);
    for (int i = 0; i < 9 && i < emits.size(); i++) begin
      chk($sformatf("%s_pos%0d", tag, i), 32'(emits[i]), 32'(base + exp_a[i]));
      check_win($sformatf("%s_w%0d", tag, i), wins[i], exp_a[i], 8);
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_a  = $urandom;
      valid_a = i[0];
      @(posedge clk); #1;
    end
    valid_a = 1'b0;
    chk("rst_taps_a", 32'(pa != '0), 32'd0);
    chk("rst_valid_a", 32'(va), 32'd0);
    chk("rst_done_a", 32'(fda), 32'd0);
    chk("rst_taps_b", 32'(pb != '0), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) idle(0);
    chk("post_rst_taps", 32'(pa != '0), 32'd0);
    chk("post_rst_stray", 32'(stray), 32'd0);

    clear_log();
    for (int k = 0; k < 64; k++) beat(0, 32'(k), k);
    check_frame_a("basic", 0);
    chk("basic_n_done", 32'(fds.size()), 32'd1);
    if (fds.size() > 0) chk("basic_done_pos", 32'(fds[0]), 32'd63);

    clear_log();
    for (int k = 0; k < 64; k++) begin
      int gap;
      beat(0, 32'(k), k);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) idle(0);
    end
    check_frame_a("gap", 0);
    chk("gap_stray", 32'(stray), 32'd0);
    chk("gap_n_done", 32'(fds.size()), 32'd1);

    clear_log();
    for (int k = 0; k < 128; k++) beat(0, 32'(k), k);
    chk("b2b_n_emit", 32'(emits.size()), 32'd18);
    chk("b2b_n_done", 32'(fds.size()), 32'd2);
    if (fds.size() == 2) chk("b2b_done2_pos", 32'(fds[1]), 32'd127);
    if (emits.size() >= 10) begin
      chk("b2b_w9_pos", 32'(emits[9]), 32'd82);
      check_win("b2b_w9", wins[9], 82, 8);
    end

    for (int k = 0; k < 30; k++) beat(0, 32'(1000 + k), k);
    rst = 1'b0;
    idle(0);
    idle(0);
    rst = 1'b1;
    clear_log();
    for (int k = 0; k < 64; k++) beat(0, 32'(k), k);
    check_frame_a("midrst", 0);
    chk("midrst_n_done", 32'(fds.size()), 32'd1);

    clear_log();
    for (int k = 0; k < 25; k++) beat(1, 32'(k), k);
    chk("s1_n_emit", 32'(emits.size()), 32'd9);
    for (int i = 0; i < 9 && i < emits.size(); i++) begin
      chk($sformatf("s1_pos%0d", i), 32'(emits[i]), 32'(exp_b[i]));
    end
    if (wins.size() == 9) check_win("s1_last", wins[8], 24, 5);
    chk("s1_n_done", 32'(fds.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxpool_window_gen.md
# maxpool_window_gen

Raster-to-window producer for the 3x3 max-pooling comparator tree. It accepts one FP32 feature-map pixel per valid beat in row-major order and buffers two previous rows in line buffers. At every stride-aligned position it presents a complete 3x3 window as nine parallel 32-bit taps with a one-cycle valid strobe. It sits between the convolution/activation output stream and the 3x3 max finder, and is the sending side of that nine-tap valid interface.

## Interface
- DATA_WIDTH, 32: pixel width; data is opaque and never interpreted.
- IMG_WIDTH, 8: columns per row; legal range >= 3.
- IMG_HEIGHT, 8: rows per frame; legal range >= 3.
- STRIDE, 2: pooling stride in both axes; legal range 1..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  pixel, raster order.
- valid_in  in  1  pixel accepted on any rising clk edge where it is high; no backpressure.
- data_out0..data_out8  out  DATA_WIDTH each  window taps, row-major: data_out0 = (r-2,c-2), data_out2 = (r-2,c), data_out6 = (r,c-2), data_out8 = (r,c).
- valid_out  out  1  one-cycle strobe: taps hold a new window.
- frame_done  out  1  one-cycle strobe: last pixel of the frame has been accepted.

## Operation
- Position counters: col runs 0..IMG_WIDTH-1 and row runs 0..IMG_HEIGHT-1. Both advance only on accepted beats.
  - col wraps to 0 and row increments at end of line.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0. The next beat is pixel (0,0) of a new frame.
- Line buffers:
  - lb0 holds row r-1 and lb1 holds row r-2, each IMG_WIDTH entries.
  - On an accepted beat at column c, read lb0[c] and lb1[c], then write lb1[c] <= lb0[c] and lb0[c] <= data_in in the same cycle.
- Window register: 3x3 array of DATA_WIDTH.
  - On each accepted beat, columns shift left by one.
  - The new rightmost column is {lb1[c], lb0[c], data_in} (top, middle, bottom).
  - The taps drive the window register directly.
- Emit condition, evaluated on the accepted beat:
  - row >= 2 and col >= 2;
  - (row-2) % STRIDE == 0;
  - (col-2) % STRIDE == 0.
  - Because col >= 2, a window never spans a line boundary.
- Windows per frame: ((IMG_WIDTH-3)/STRIDE+1) * ((IMG_HEIGHT-3)/STRIDE+1), using integer division.
- Line buffers are not cleared by reset. Rows 0 and 1 of each frame fully rewrite them before any emit, so stale contents never reach an emitted window.
- Idle cycles (valid_in low) change no state. They may occur anywhere, including mid-row and between frames.

## Timing
- Reset values:
  - all counters 0;
  - window register 0, so data_out0..8 = 0;
  - valid_out = 0, frame_done = 0.
- Reset is asynchronous assert and synchronous-edge release. A reset mid-frame discards the partial frame, and the next accepted beat is pixel (0,0).
- Latency: valid_out rises on the edge that accepts the pixel at (r,c) meeting the emit condition, so it is visible the cycle after valid_in. The taps are valid in that same cycle.
- Tap hold: taps change on every accepted beat, including non-emit beats. The consumer must sample only while valid_out is high.
- valid_out is high for exactly one cycle per window. Back-to-back windows are impossible for STRIDE >= 2. For STRIDE = 1 they occur on consecutive accepted beats.
- frame_done rises on the same edge as the last pixel's acceptance. It coincides with the final valid_out whenever the last pixel is an emit position.
- Throughput: one pixel per clock, sustained indefinitely across frame boundaries, with no dead cycles.

## Test plan
- Reset: with rst low, valid_in toggling and random data, expect all outputs 0. After release with no valid_in, outputs stay 0.
- Basic frame: 8x8, STRIDE=2, pixel k = k (k = 0..63), continuous beats.
  - Expect exactly 9 valid_out pulses at pixels 18, 20, 22, 34, 36, 38, 50, 52, 54.
  - The first window taps must be 0,1,2,8,9,10,16,17,18.
  - The last window taps must be 36,37,38,44,45,46,52,53,54.
  - frame_done must pulse once, after pixel 63.
- Gapped input: the same frame with random 0-3 idle cycles between beats. Expect identical window contents and count, with each pulse one cycle after its emitting beat.
- Back-to-back frames: 128 continuous beats, k = 0..127.
  - Expect 18 windows and 2 frame_done pulses.
  - The 10th window taps must be 64,65,66,72,73,74,80,81,82.
- Reset mid-frame: assert rst after 30 beats, then send a full 8x8 frame. Expect exactly 9 windows, identical to the basic frame, with no window from the aborted data.
- STRIDE=1, 5x5: pixel k = k. Expect 9 windows on consecutive beats 12, 13, 14, 17, 18, 19, 22, 23, 24. The last window taps must be 12,13,14,17,18,19,22,23,24.
